// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the music sequencer: FSM state encoding,
// ROM word field positions and address width.
package music_sequencer_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int SONG_W   = 4;
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;
  localparam int NOTE_W   = NOTE_MSB - NOTE_LSB + 1;
  localparam int DUR_W    = DUR_MSB - DUR_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_t;

endpackage

// File: rtl/music_sequencer_if.sv
// Bundle of song-control, ROM and tone-generator signals around the sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface music_sequencer_if;
  import music_sequencer_pkg::*;

  logic [SONG_W-1:0] cstate;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              beat_tick;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic              playing;
  logic              song_done;

  modport master (
    output cstate, start_addr, end_addr, beat_tick, rom_data,
    input  rom_addr, note, note_valid, playing, song_done
  );

  modport slave (
    input  cstate, start_addr, end_addr, beat_tick, rom_data,
    output rom_addr, note, note_valid, playing, song_done
  );

endinterface

// File: rtl/music_sequencer_beat_counter.sv
// Remaining-beats counter for the note being played: loaded with the note
// duration, decremented per beat tick, flags the final beat.
module music_sequencer_beat_counter
  import music_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             tick,
  output logic             is_one
);

  logic [DUR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == DUR_W'(1));

endmodule

// File: rtl/music_sequencer.sv
// Song sequencer: walks ROM words from start_addr to end_addr, sounding each
// note for its duration in beats, with looping, abort and stop handling.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int LOOP    = 1,
  parameter int ROM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  music_sequencer_if.slave bus
);

  localparam logic [1:0] WAIT_LAST = 2'(ROM_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              playing_q, playing_d;
  logic              song_done_q, song_done_d;
  logic [SONG_W-1:0] cur_song_q, cur_song_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              cnt_load, cnt_tick, cnt_one, song_end;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = bus.rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = bus.rom_data[DUR_MSB:DUR_LSB];

  music_sequencer_beat_counter u_beat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (rom_dur),
    .tick     (cnt_tick),
    .is_one   (cnt_one)
  );

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    note_d       = note_q;
    note_valid_d = note_valid_q;
    song_done_d  = 1'b0;
    cur_song_d   = cur_song_q;
    wait_cnt_d   = wait_cnt_q;
    cnt_load     = 1'b0;
    cnt_tick     = 1'b0;
    song_end     = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.cstate != '0) begin
        state_d    = S_FETCH;
        rom_addr_d = bus.start_addr;
        cur_song_d = bus.cstate;
      end
    end else if (bus.cstate == '0) begin
      state_d      = S_IDLE;
      note_valid_d = 1'b0;
    end else if (bus.cstate != cur_song_q) begin
      // A new song selection pre-empts whatever is in progress, beat included.
      state_d      = S_FETCH;
      rom_addr_d   = bus.start_addr;
      cur_song_d   = bus.cstate;
      note_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            if (rom_dur == '0) begin
              song_end = 1'b1;
            end else begin
              note_d       = rom_note;
              note_valid_d = 1'b1;
              cnt_load     = 1'b1;
              state_d      = S_PLAY;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.beat_tick) begin
            cnt_tick = 1'b1;
            if (cnt_one) begin
              note_valid_d = 1'b0;
              if (rom_addr_q == bus.end_addr) begin
                song_end = 1'b1;
              end else begin
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = S_FETCH;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Shared by the last note finishing and a zero-duration end marker.
    if (song_end) begin
      song_done_d  = 1'b1;
      note_valid_d = 1'b0;
      if (LOOP != 0) begin
        rom_addr_d = bus.start_addr;
        state_d    = S_FETCH;
      end else begin
        state_d = S_DONE;
      end
    end

    playing_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      playing_q    <= 1'b0;
      song_done_q  <= 1'b0;
      cur_song_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      playing_q    <= playing_d;
      song_done_q  <= song_done_d;
      cur_song_q   <= cur_song_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.note       = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.playing    = playing_q;
  assign bus.song_done  = song_done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: one LOOP=0 and one LOOP=1 instance
// share song inputs; expected notes, song ends and output snapshots are queued.
module tb_music_sequencer;

  typedef enum int {EV_NOTE, EV_DONE, EV_SNAP} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    int          dut;
    logic [9:0]  addr;
    logic [3:0]  note;
    int          beats;
    logic        nv;
    logic        play;
    logic        done;
    bit          chk_note;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       beat_tick;
  logic [3:0] cs0, cs1;
  logic [9:0] start_addr, end_addr;
  logic [7:0] rom [1024];

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  snap_req = 0;
  int  snap_ack = 0;
  int  snap_dut = 0;
  bit  end_req = 1'b0;

  logic       nv_s   [2];
  logic       play_s [2];
  logic       done_s [2];
  logic [9:0] addr_s [2];
  logic [3:0] note_s [2];
  logic       nv_prev  [2];
  logic [9:0] cur_addr [2];
  logic [3:0] cur_note [2];
  int         beats    [2];

  music_sequencer_if bus0 ();
  music_sequencer_if bus1 ();

  music_sequencer #(.LOOP(0), .ROM_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  music_sequencer #(.LOOP(1), .ROM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus0.cstate     = cs0;
  assign bus1.cstate     = cs1;
  assign bus0.start_addr = start_addr;
  assign bus1.start_addr = start_addr;
  assign bus0.end_addr   = end_addr;
  assign bus1.end_addr   = end_addr;
  assign bus0.beat_tick  = beat_tick;
  assign bus1.beat_tick  = beat_tick;

  assign nv_s[0]   = bus0.note_valid;
  assign nv_s[1]   = bus1.note_valid;
  assign play_s[0] = bus0.playing;
  assign play_s[1] = bus1.playing;
  assign done_s[0] = bus0.song_done;
  assign done_s[1] = bus1.song_done;
  assign addr_s[0] = bus0.rom_addr;
  assign addr_s[1] = bus1.rom_addr;
  assign note_s[0] = bus0.note;
  assign note_s[1] = bus1.note;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM with one clock of read latency per instance.
  always @(posedge clk) begin
    bus0.rom_data <= rom[bus0.rom_addr];
    bus1.rom_data <= rom[bus1.rom_addr];
  end

  function automatic ev_t mk_ev(input ev_kind_t k, input int d, input logic [9:0] a,
                                input logic [3:0] n, input int b, input logic nv,
                                input logic pl, input logic dn, input bit cn);
    ev_t e;
    e.kind = k; e.dut = d; e.addr = a; e.note = n; e.beats = b;
    e.nv = nv; e.play = pl; e.done = dn; e.chk_note = cn;
    return e;
  endfunction

  task automatic check_output(input ev_t act, input string name);
    ev_t exp;
    bit  ok;
    checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL %s: got unexpected dut%0d kind=%0d addr=%h note=%h beats=%0d, required no event",
               name, act.dut, act.kind, act.addr, act.note, act.beats);
      return;
    end
    exp = exp_q.pop_front();
    ok = (act.kind == exp.kind) && (act.dut == exp.dut) && (act.addr == exp.addr);
    if (exp.kind == EV_NOTE)
      ok = ok && (act.note == exp.note) && (act.beats == exp.beats);
    if (exp.kind == EV_SNAP)
      ok = ok && (act.nv == exp.nv) && (act.play == exp.play) && (act.done == exp.done)
              && (!exp.chk_note || act.note == exp.note);
    if (ok) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got dut%0d kind=%0d addr=%h note=%h beats=%0d nv=%b play=%b done=%b, required dut%0d kind=%0d addr=%h note=%h beats=%0d nv=%b play=%b done=%b",
               name, act.dut, act.kind, act.addr, act.note, act.beats, act.nv, act.play, act.done,
               exp.dut, exp.kind, exp.addr, exp.note, exp.beats, exp.nv, exp.play, exp.done);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them in order.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (nv_s[i] && !nv_prev[i]) begin
        cur_addr[i] = addr_s[i];
        cur_note[i] = note_s[i];
        beats[i]    = 0;
      end
      if (nv_s[i] && beat_tick)
        beats[i] = beats[i] + 1;
      if (!nv_s[i] && nv_prev[i])
        check_output(mk_ev(EV_NOTE, i, cur_addr[i], cur_note[i], beats[i], 1'b0, 1'b0, 1'b0, 1'b0), "note");
      if (done_s[i])
        check_output(mk_ev(EV_DONE, i, addr_s[i], 4'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0), "song_done");
      nv_prev[i] = nv_s[i];
    end
    if (snap_req != snap_ack) begin
      check_output(mk_ev(EV_SNAP, snap_dut, addr_s[snap_dut], note_s[snap_dut], 0,
                         nv_s[snap_dut], play_s[snap_dut], done_s[snap_dut], 1'b0), "snapshot");
      snap_ack = snap_req;
    end
    if (end_req) begin
      checks++;
      if (exp_q.size() == 0)
        passes++;
      else
        $display("[TB] FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      repeat (7) @(posedge clk);
      #1 beat_tick = 1'b1;
      @(posedge clk);
      #1 beat_tick = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input int d, input logic [3:0] song,
                                input logic [9:0] s, input logic [9:0] e);
    start_addr = s;
    end_addr   = e;
    if (d == 0) cs0 = song;
    else        cs1 = song;
  endtask

  task automatic push_note(input int d, input logic [9:0] a, input logic [3:0] n, input int b);
    exp_q.push_back(mk_ev(EV_NOTE, d, a, n, b, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_done(input int d, input logic [9:0] a);
    exp_q.push_back(mk_ev(EV_DONE, d, a, 4'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic request_snap(input int d, input logic [9:0] a, input logic [3:0] n, input bit cn,
                              input logic nv, input logic pl, input logic dn);
    exp_q.push_back(mk_ev(EV_SNAP, d, a, n, 0, nv, pl, dn, cn));
    snap_dut = d;
    snap_req++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      nv_prev[i] = 1'b0; cur_addr[i] = '0; cur_note[i] = '0; beats[i] = 0;
    end
    rst = 1'b1; beat_tick = 1'b0; cs0 = '0; cs1 = '0;
    start_addr = '0; end_addr = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    rom[10'h010] = 8'h52; rom[10'h011] = 8'h71; rom[10'h012] = 8'h93;
    rom[10'h3FE] = 8'h11; rom[10'h3FF] = 8'h21; rom[10'h000] = 8'h31; rom[10'h001] = 8'h41;
    rom[10'h020] = 8'hA2; rom[10'h021] = 8'hB1;

    $display("[TB] reset state");
    cycles(3);
    request_snap(0, 10'h000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycles(1);
    request_snap(1, 10'h000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycles(2);

    $display("[TB] three-note song, no loop");
    push_note(0, 10'h010, 4'h5, 2);
    push_note(0, 10'h011, 4'h7, 1);
    push_note(0, 10'h012, 4'h9, 3);
    push_done(0, 10'h012);
    apply_stimulus(0, 4'd1, 10'h010, 10'h012);
    run_ticks(7);
    request_snap(0, 10'h012, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cs0 = 4'd0;
    cycles(2);
    request_snap(0, 10'h012, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(1);

    $display("[TB] three-note song, looping");
    push_note(1, 10'h010, 4'h5, 2);
    push_note(1, 10'h011, 4'h7, 1);
    push_note(1, 10'h012, 4'h9, 3);
    push_done(1, 10'h010);
    push_note(1, 10'h010, 4'h5, 2);
    push_note(1, 10'h011, 4'h7, 1);
    apply_stimulus(1, 4'd1, 10'h010, 10'h012);
    run_ticks(9);
    cs1 = 4'd0;
    cycles(2);
    request_snap(1, 10'h012, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(1);

    $display("[TB] address wrap 0x3FE..0x001");
    push_note(0, 10'h3FE, 4'h1, 1);
    push_note(0, 10'h3FF, 4'h2, 1);
    push_note(0, 10'h000, 4'h3, 1);
    push_note(0, 10'h001, 4'h4, 1);
    push_done(0, 10'h001);
    apply_stimulus(0, 4'd3, 10'h3FE, 10'h001);
    run_ticks(5);
    request_snap(0, 10'h001, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cs0 = 4'd0;
    cycles(2);

    $display("[TB] zero-duration end marker");
    rom[10'h011] = 8'h70;
    push_note(0, 10'h010, 4'h5, 2);
    push_done(0, 10'h011);
    apply_stimulus(0, 4'd1, 10'h010, 10'h012);
    run_ticks(4);
    request_snap(0, 10'h011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cs0 = 4'd0;
    cycles(2);
    rom[10'h011] = 8'h71;

    $display("[TB] song change and stop mid-note");
    apply_stimulus(0, 4'd1, 10'h010, 10'h012);
    cycles(4);
    push_note(0, 10'h010, 4'h5, 0);
    apply_stimulus(0, 4'd2, 10'h020, 10'h021);
    cycles(1);
    request_snap(0, 10'h020, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycles(4);
    push_note(0, 10'h020, 4'hA, 0);
    cs0 = 4'd0;
    cycles(1);
    request_snap(0, 10'h020, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(2);

    $display("[TB] reset mid-note and restart");
    apply_stimulus(1, 4'd1, 10'h010, 10'h012);
    cycles(4);
    push_note(1, 10'h010, 4'h5, 0);
    rst = 1'b1;
    cycles(1);
    request_snap(1, 10'h000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cs1 = 4'd0;
    cycles(1);
    request_snap(0, 10'h000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycles(1);
    rst = 1'b0;
    cycles(1);
    push_note(1, 10'h010, 4'h5, 2);
    apply_stimulus(1, 4'd1, 10'h010, 10'h012);
    run_ticks(2);
    cs1 = 4'd0;
    cycles(2);
    request_snap(1, 10'h011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(2);

    end_req = 1'b1;
  end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter LOOP, default 1, meaning: 1 = restart at start_addr after end_addr; 0 = stop after end_addr.
REQ-002 SHALL have parameter ROM_LAT, default 1, meaning: ROM read latency in clocks, legal range 1..3.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cstate, input, 4 bits: song select from the state controller; 0 = stop.
REQ-006 SHALL have port start_addr, input, 10 bits: first ROM address of the selected song.
REQ-007 SHALL have port end_addr, input, 10 bits: last ROM address of the selected song.
REQ-008 SHALL have port beat_tick, input, 1 bit: one-cycle tempo pulse.
REQ-009 SHALL have port rom_data, input, 8 bits: [7:4] note code (0 = rest), [3:0] duration in beats.
REQ-010 SHALL have port rom_addr, output, 10 bits: ROM read address.
REQ-011 SHALL have port note, output, 4 bits: current note code to the tone generator.
REQ-012 SHALL have port note_valid, output, 1 bit: high while note is sounding.
REQ-013 SHALL have port playing, output, 1 bit: high in every state except IDLE and DONE.
REQ-014 SHALL have port song_done, output, 1 bit: one-cycle pulse at song end.

Function
REQ-015 SHALL implement states IDLE, FETCH, WAIT, PLAY, DONE; all outputs registered.
REQ-016 In IDLE, cstate!=0 sampled at edge E SHALL cause: FETCH at E, rom_addr=start_addr, and latch cstate as cur_song.
REQ-017 FETCH SHALL last 1 cycle, then WAIT.
REQ-018 WAIT SHALL last ROM_LAT cycles, then capture rom_data: note<=rom_data[7:4], beat_cnt<=rom_data[3:0], note_valid<=1, go to PLAY.
REQ-019 Latency with ROM_LAT=1: note_valid SHALL rise at edge E+2 relative to the IDLE start edge or the PLAY exit edge.
REQ-020 Duration 0 SHALL be an end-of-song marker: no note is sounded; behave as end reached (REQ-023).
REQ-021 In PLAY, each beat_tick SHALL decrement beat_cnt.
REQ-022 When beat_tick arrives with beat_cnt==1 and rom_addr!=end_addr: note_valid<=0, rom_addr<=rom_addr+1 (mod 1024, 1023 wraps to 0), go to FETCH.
REQ-023 When beat_tick arrives with beat_cnt==1 and rom_addr==end_addr: pulse song_done one cycle, note_valid<=0; LOOP=1 -> rom_addr<=start_addr, go to FETCH; LOOP=0 -> go to DONE.
REQ-024 beat_tick SHALL be ignored outside PLAY.
REQ-025 end_addr<start_addr SHALL be legal: addresses advance through 1023->0 until end_addr.
REQ-026 In any non-IDLE state, cstate==0 SHALL force IDLE next edge with note_valid=0; song_done is not pulsed.
REQ-027 In any non-IDLE state, cstate!=cur_song and cstate!=0 SHALL abort: next edge FETCH at new start_addr, cur_song updated, note_valid=0; song_done is not pulsed.
REQ-028 DONE SHALL hold until cstate changes (to 0 -> IDLE; to a new song -> FETCH per REQ-027).
REQ-029 Abort (REQ-026, REQ-027) SHALL take priority over beat_tick in the same cycle.
REQ-030 start_addr/end_addr SHALL be sampled continuously; the end comparison uses current end_addr.

Reset
REQ-031 rst high at a posedge SHALL set: state=IDLE, rom_addr=0, note=0, note_valid=0, playing=0, song_done=0, beat_cnt=0, cur_song=0, wait counter=0.
REQ-032 rst SHALL override all other inputs, including mid-note; operation resumes per REQ-016 after release.

Structure
REQ-033 State encoding, ROM field positions (NOTE_MSB/LSB, DUR_MSB/LSB), and ADDR_W=10 SHALL live in a shared music package.
REQ-034 A sub-module beat_counter (load, tick-decrement, ==1 flag) is natural; the FSM stays in music_sequencer.

Verification
REQ-035 Bench SHALL cover:
- Song at start 0x010..0x012, durations 2,1,3, beat_tick every 8 clocks, LOOP=0 -> note_valid for 2,1,3 beats; rom_addr 0x010,0x011,0x012; one song_done; then DONE.
- Same song with LOOP=1 -> song_done pulse, then rom_addr returns to 0x010 and the note sequence repeats.
- start_addr=0x3FE, end_addr=0x001 -> rom_addr visits 0x3FE,0x3FF,0x000,0x001.
- Word at 0x011 with duration 0 -> song ends after 0x010; song_done pulses, 0x012 is never fetched.
- cstate 1->2 mid-note -> next edge FETCH at song 2 start_addr, no song_done; cstate->0 -> IDLE, note_valid=0.
- rst asserted mid-PLAY -> next edge all outputs 0, state IDLE.
